// File: rtl/timer_irq_source.sv
// Programmable interval timer that raises a level interrupt request on each expiry.
// The request is held until the CPU acknowledges it; expiries lost meanwhile are counted.
module timer_irq_source #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned OVR_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we_cfg,
  input  logic [1:0]       cfg_sel,
  input  logic [WIDTH-1:0] wdata,
  input  logic             ack,
  output logic             irq,
  output logic [WIDTH-1:0] count,
  output logic [OVR_W-1:0] overrun,
  output logic             running
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           r_state, w_state_next;
  logic [WIDTH-1:0] r_reload, r_prescale;
  logic             r_per;
  logic [WIDTH-1:0] r_pre_cnt, w_pre_cnt_next;
  logic [WIDTH-1:0] r_count, w_count_next;
  logic             r_irq, w_irq_next;
  logic [OVR_W-1:0] r_overrun, w_overrun_next;

  logic w_ctrl_wr;
  logic w_tick;
  logic w_expiry;

  assign w_ctrl_wr = we_cfg && (cfg_sel == 2'd2);
  assign w_tick    = (r_state == StRun) && (r_pre_cnt == r_prescale);
  // CTRL write takes priority over tick and expiry.
  assign w_expiry  = w_tick && (r_count == '0) && !w_ctrl_wr;

  always_comb begin
    w_state_next   = r_state;
    w_pre_cnt_next = r_pre_cnt;
    w_count_next   = r_count;
    if (w_ctrl_wr) begin
      if (wdata[0]) begin
        w_state_next   = StRun;
        w_count_next   = r_reload;
        w_pre_cnt_next = '0;
      end else if (r_state == StRun) begin
        w_state_next = StIdle;
      end
    end else if (r_state == StRun) begin
      w_pre_cnt_next = w_tick ? '0 : r_pre_cnt + 1'b1;
      if (w_tick) begin
        if (r_count != '0) begin
          w_count_next = r_count - 1'b1;
        end else if (r_per) begin
          w_count_next = r_reload;
        end else begin
          w_state_next = StDone;
        end
      end
    end
  end

  always_comb begin
    w_irq_next     = r_irq;
    w_overrun_next = r_overrun;
    if (w_expiry) begin
      w_irq_next = 1'b1;
      if (r_irq && !ack && (r_overrun != '1)) begin
        w_overrun_next = r_overrun + 1'b1;
      end
    end else if (ack) begin
      w_irq_next = 1'b0;
    end
    // Clear beats a simultaneous lost expiry.
    if (w_ctrl_wr && wdata[2]) begin
      w_overrun_next = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= StIdle;
      r_reload   <= '0;
      r_prescale <= '0;
      r_per      <= 1'b0;
      r_pre_cnt  <= '0;
      r_count    <= '0;
      r_irq      <= 1'b0;
      r_overrun  <= '0;
    end else begin
      r_state   <= w_state_next;
      r_pre_cnt <= w_pre_cnt_next;
      r_count   <= w_count_next;
      r_irq     <= w_irq_next;
      r_overrun <= w_overrun_next;
      if (we_cfg && (cfg_sel == 2'd0)) r_reload   <= wdata;
      if (we_cfg && (cfg_sel == 2'd1)) r_prescale <= wdata;
      if (w_ctrl_wr)                   r_per      <= wdata[1];
    end
  end

  assign irq     = r_irq;
  assign count   = r_count;
  assign overrun = r_overrun;
  assign running = (r_state == StRun);

endmodule

// File: tb/tb_timer_irq_source.sv
// Directed bench for timer_irq_source: reset, periodic, one-shot, overrun, ack/expiry race,
// and reset in mid-run, each step checked against hand-computed values.
module tb_timer_irq_source;

  logic       clk;
  logic       reset;
  logic       we_cfg;
  logic [1:0] cfg_sel;
  logic [7:0] wdata;
  logic       ack;
  logic       irq;
  logic [7:0] count;
  logic [3:0] overrun;
  logic       running;

  int checks = 0;
  int errors = 0;

  timer_irq_source #(
    .WIDTH(8),
    .OVR_W(4)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .we_cfg (we_cfg),
    .cfg_sel(cfg_sel),
    .wdata  (wdata),
    .ack    (ack),
    .irq    (irq),
    .count  (count),
    .overrun(overrun),
    .running(running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [1:0] sel, input logic [7:0] d);
    we_cfg  = 1'b1;
    cfg_sel = sel;
    wdata   = d;
    step(1);
    we_cfg  = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  int exp_cnt[8] = '{3, 3, 2, 2, 1, 1, 0, 0};

  initial begin
    reset = 1'b1; ack = 1'b1; we_cfg = 1'b1; cfg_sel = 2'd2; wdata = 8'd3;
    step(2);
    chk("rst_irq", irq, 0);
    chk("rst_count", count, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_running", running, 0);
    reset = 1'b0; ack = 1'b0; we_cfg = 1'b0;
    step(1);
    chk("rst_post_running", running, 0);

    // Periodic: RELOAD=3, PRESCALE=1 -> expiry every 8 cycles
    wr(2'd0, 8'd3);
    wr(2'd1, 8'd1);
    wr(2'd2, 8'd3);
    chk("per_running", running, 1);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("per_count%0d", i), count, exp_cnt[i]);
      chk($sformatf("per_irq_low%0d", i), irq, 0);
      step(1);
    end
    chk("per_irq_rise1", irq, 1);
    chk("per_reload", count, 3);
    step(2);
    ack = 1'b1;
    step(1);
    ack = 1'b0;
    chk("per_ack_clear", irq, 0);
    step(4);
    chk("per_irq_before2", irq, 0);
    step(1);
    chk("per_irq_rise2", irq, 1);
    chk("per_overrun", overrun, 0);
    ack = 1'b1;
    step(1);
    ack = 1'b0;
    chk("per_ack2", irq, 0);
    wr(2'd2, 8'd0);
    chk("stop_running", running, 0);
    chk("stop_count_hold", count, 3);

    // One-shot: RELOAD=2, PRESCALE=0
    wr(2'd0, 8'd2);
    wr(2'd1, 8'd0);
    wr(2'd2, 8'd1);
    chk("os_load", count, 2);
    chk("os_running", running, 1);
    step(1);
    chk("os_count1", count, 1);
    step(1);
    chk("os_count0", count, 0);
    chk("os_irq_pre", irq, 0);
    step(1);
    chk("os_irq", irq, 1);
    chk("os_done_running", running, 0);
    chk("os_done_count", count, 0);
    step(1);
    chk("os_done_hold", count, 0);
    chk("os_done_hold_run", running, 0);
    ack = 1'b1;
    step(1);
    ack = 1'b0;
    chk("os_ack", irq, 0);
    wr(2'd2, 8'd1);
    chk("os_restart_count", count, 2);
    chk("os_restart_running", running, 1);
    step(1);
    chk("os_restart_dec", count, 1);
    wr(2'd2, 8'd0);
    chk("os_stop_running", running, 0);
    chk("os_stop_count", count, 1);

    // Overrun: RELOAD=0, PRESCALE=0, periodic, no ack
    wr(2'd0, 8'd0);
    wr(2'd1, 8'd0);
    wr(2'd2, 8'd3);
    chk("ovr_irq0", irq, 0);
    chk("ovr_cnt0", overrun, 0);
    step(1);
    chk("ovr_irq1", irq, 1);
    chk("ovr_cnt1", overrun, 0);
    step(1);
    chk("ovr_cnt2", overrun, 1);
    step(3);
    chk("ovr_cnt5", overrun, 4);
    step(15);
    chk("ovr_sat", overrun, 15);
    chk("ovr_irq_held", irq, 1);
    wr(2'd2, 8'd7);
    chk("ovr_clear", overrun, 0);
    chk("ovr_clear_irq", irq, 1);
    chk("ovr_clear_running", running, 1);
    step(1);
    chk("ovr_after_clear", overrun, 1);

    // ack coinciding with expiry keeps the request and the overrun count
    ack = 1'b1;
    step(1);
    ack = 1'b0;
    chk("race_irq", irq, 1);
    chk("race_overrun", overrun, 1);
    step(1);
    chk("race_next_lost", overrun, 2);
    wr(2'd2, 8'd2);
    chk("race_stop_running", running, 0);
    chk("race_stop_overrun", overrun, 2);
    chk("race_stop_irq", irq, 1);
    ack = 1'b1;
    step(1);
    chk("lone_ack", irq, 0);
    step(1);
    ack = 1'b0;
    chk("ack_idle_ignored", irq, 0);

    // Reset mid-run with irq=1 and count=2
    wr(2'd0, 8'd2);
    wr(2'd1, 8'd3);
    wr(2'd2, 8'd3);
    chk("mr_load", count, 2);
    step(11);
    chk("mr_pre_irq", irq, 0);
    chk("mr_pre_count", count, 0);
    step(1);
    chk("mr_irq", irq, 1);
    chk("mr_count", count, 2);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk("mr_rst_irq", irq, 0);
    chk("mr_rst_count", count, 0);
    chk("mr_rst_overrun", overrun, 0);
    chk("mr_rst_running", running, 0);
    wr(2'd2, 8'd1);
    chk("mr_reload_zero", count, 0);
    chk("mr_rerun", running, 1);
    step(1);
    chk("mr_prescale_zero_irq", irq, 1);
    chk("mr_prescale_zero_done", running, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
